pipeline_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage in-order core. Successor to the core's fixed, hazard-blind stage buffering.
- Tracks destination and valid state of every in-flight instruction past decode, over NSTAGES stages.
- Produces, for the decode-stage instruction:
  - per-operand forwarding selects
  - load-use stall
  - branch/jump flush
  - saturating stall/flush performance counters
- Sits beside the decoder and register bank; drives the PC hold, the decode-buffer hold and the operand muxes.

---
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Decode-side bus between the decoder and the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int ADDRW   = 5,
    parameter int NSTAGES = 3,
    parameter int COUNTW  = 32
);
    localparam int SELW = $clog2(NSTAGES + 1);

    logic               id_valid;
    logic [ADDRW-1:0]   id_rs1;
    logic [ADDRW-1:0]   id_rs2;
    logic               id_rs1_used;
    logic               id_rs2_used;
    logic [ADDRW-1:0]   id_rd;
    logic               id_regwrite;
    logic               id_memread;
    logic               ex_redirect;
    logic [SELW-1:0]    fwd1_sel;
    logic [SELW-1:0]    fwd2_sel;
    logic               stall;
    logic               flush;
    logic [NSTAGES-1:0] stage_valid;
    logic [COUNTW-1:0]  stall_count;
    logic [COUNTW-1:0]  flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, ex_redirect,
        input  fwd1_sel, fwd2_sel, stall, flush, stage_valid,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, ex_redirect,
        output fwd1_sel, fwd2_sel, stall, flush, stage_valid,
               stall_count, flush_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Operand forwarding, load-use stall and redirect flush control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int ADDRW      = 5,
    parameter int NSTAGES    = 3,
    parameter int LOAD_READY = 2,
    parameter int COUNTW     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int SELW = $clog2(NSTAGES + 1);
    localparam logic [COUNTW-1:0] c_count_max = {COUNTW{1'b1}};

    logic [NSTAGES:1]            r_valid;
    logic [NSTAGES:1]            r_wr;
    logic [NSTAGES:1]            r_ld;
    logic [NSTAGES:1][ADDRW-1:0] r_rd;
    logic [COUNTW-1:0]           r_stall_count;
    logic [COUNTW-1:0]           r_flush_count;

    logic [SELW-1:0] w_sel1;
    logic [SELW-1:0] w_sel2;
    logic            w_hz1;
    logic            w_hz2;
    logic            w_flush;
    logic            w_stall;
    logic            w_issue;

    function automatic logic f_match(input int k, input logic [ADDRW-1:0] rs,
                                     input logic used);
        return r_valid[k] && r_wr[k] && (r_rd[k] == rs) && (rs != '0) && used;
    endfunction

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        w_hz1  = 1'b0;
        w_hz2  = 1'b0;
        for (int k = NSTAGES; k >= 1; k--) begin
            if (f_match(k, bus.id_rs1, bus.id_rs1_used)) begin
                w_sel1 = SELW'(k);
                w_hz1  = r_ld[k] && (k < LOAD_READY);
            end
            if (f_match(k, bus.id_rs2, bus.id_rs2_used)) begin
                w_sel2 = SELW'(k);
                w_hz2  = r_ld[k] && (k < LOAD_READY);
            end
        end
    end

    assign w_flush = bus.ex_redirect && r_valid[1];
    assign w_stall = bus.id_valid && (w_hz1 || w_hz2) && !w_flush;
    assign w_issue = bus.id_valid && !w_stall && !w_flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid       <= '0;
            r_wr          <= '0;
            r_ld          <= '0;
            r_rd          <= '0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_valid[1] <= w_issue;
            r_wr[1]    <= w_issue && bus.id_regwrite && (bus.id_rd != '0);
            r_ld[1]    <= w_issue && bus.id_memread;
            r_rd[1]    <= w_issue ? bus.id_rd : '0;
            for (int k = 2; k <= NSTAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_wr[k]    <= r_wr[k-1];
                r_ld[k]    <= r_ld[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            if (w_stall && (r_stall_count != c_count_max)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
            if (w_flush && (r_flush_count != c_count_max)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign bus.fwd1_sel    = w_sel1;
    assign bus.fwd2_sel    = w_sel2;
    assign bus.stall       = w_stall;
    assign bus.flush       = w_flush;
    assign bus.stage_valid = r_valid;
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed bench; a second instance with 2-bit counters shares stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_failures;

    pipeline_hazard_ctrl_if #(.ADDRW(5), .NSTAGES(3), .COUNTW(32)) bus_a ();
    pipeline_hazard_ctrl_if #(.ADDRW(5), .NSTAGES(3), .COUNTW(2))  bus_b ();

    pipeline_hazard_ctrl #(.ADDRW(5), .NSTAGES(3), .LOAD_READY(2), .COUNTW(32)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pipeline_hazard_ctrl #(.ADDRW(5), .NSTAGES(3), .LOAD_READY(2), .COUNTW(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_b.id_valid    = bus_a.id_valid;
    assign bus_b.id_rs1      = bus_a.id_rs1;
    assign bus_b.id_rs2      = bus_a.id_rs2;
    assign bus_b.id_rs1_used = bus_a.id_rs1_used;
    assign bus_b.id_rs2_used = bus_a.id_rs2_used;
    assign bus_b.id_rd       = bus_a.id_rd;
    assign bus_b.id_regwrite = bus_a.id_regwrite;
    assign bus_b.id_memread  = bus_a.id_memread;
    assign bus_b.ex_redirect = bus_a.ex_redirect;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        bus_a.id_valid    = v;
        bus_a.id_rs1      = rs1;
        bus_a.id_rs2      = rs2;
        bus_a.id_rs1_used = u1;
        bus_a.id_rs2_used = u2;
        bus_a.id_rd       = rd;
        bus_a.id_regwrite = rw;
        bus_a.id_memread  = mr;
        #1;
    endtask

    task automatic idle();
        bus_a.ex_redirect = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Inputs change 1 time unit after the rising edge, checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    initial begin
        n_checks   = 0;
        n_failures = 0;

        // Reset held with live-looking inputs
        reset = 1'b0;
        bus_a.ex_redirect = 1'b1;
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        repeat (3) tick();
        #1;
        check("rst_stage_valid", bus_a.stage_valid, 0);
        check("rst_stall", bus_a.stall, 0);
        check("rst_flush", bus_a.flush, 0);
        check("rst_fwd1", bus_a.fwd1_sel, 0);
        check("rst_fwd2", bus_a.fwd2_sel, 0);
        check("rst_stall_cnt", bus_a.stall_count, 0);
        check("rst_flush_cnt", bus_a.flush_count, 0);
        idle();
        reset = 1'b1;
        tick();

        // ALU chain: add x5 then sub x6,x5, reader held in ID over bubbles
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        check("alu_fwd1_ex", bus_a.fwd1_sel, 1);
        check("alu_fwd2_none", bus_a.fwd2_sel, 0);
        check("alu_stall", bus_a.stall, 0);
        check("alu_sv_b", bus_a.stage_valid, 3'b001);
        tick();
        drive(1'b0, 5'd5, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("alu_fwd1_mem", bus_a.fwd1_sel, 2);
        check("alu_sv_c", bus_a.stage_valid, 3'b011);
        tick();
        check("alu_fwd1_wb", bus_a.fwd1_sel, 3);
        check("alu_sv_d", bus_a.stage_valid, 3'b110);
        tick();
        check("alu_fwd1_gone", bus_a.fwd1_sel, 0);
        check("alu_sv_e", bus_a.stage_valid, 3'b100);
        drain();
        check("drain1_sv", bus_a.stage_valid, 0);

        // Load-use: lw x6 then add x7,x6,x6
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        check("lu_stall", bus_a.stall, 1);
        check("lu_fwd1_ex", bus_a.fwd1_sel, 1);
        check("lu_fwd2_ex", bus_a.fwd2_sel, 1);
        tick();
        check("lu_stall_done", bus_a.stall, 0);
        check("lu_fwd1_mem", bus_a.fwd1_sel, 2);
        check("lu_fwd2_mem", bus_a.fwd2_sel, 2);
        check("lu_sv_bubble", bus_a.stage_valid, 3'b010);
        check("lu_stall_cnt", bus_a.stall_count, 1);
        check("lu_flush_cnt", bus_a.flush_count, 0);
        tick();
        check("lu_sv_issued", bus_a.stage_valid, 3'b101);
        drain();

        // Youngest writer wins; x0 never forwards
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        check("prio_fwd1", bus_a.fwd1_sel, 1);
        check("prio_fwd2", bus_a.fwd2_sel, 1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        check("x0_fwd1", bus_a.fwd1_sel, 0);
        check("x0_fwd2", bus_a.fwd2_sel, 0);
        check("x0_stall", bus_a.stall, 0);
        drain();

        // Redirect overrides a pending load-use stall
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1);
        tick();
        bus_a.ex_redirect = 1'b1;
        drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        check("rd_flush", bus_a.flush, 1);
        check("rd_stall", bus_a.stall, 0);
        check("rd_fwd1", bus_a.fwd1_sel, 1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("rd_sv", bus_a.stage_valid, 3'b010);
        check("rd_flush_cnt", bus_a.flush_count, 1);
        check("rd_stall_cnt", bus_a.stall_count, 1);
        check("rd_ignored", bus_a.flush, 0);
        drain();

        // Saturation on the 2-bit instance, then a mid-run reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
            check("sat_stall", bus_b.stall, 1);
            tick();
            check("sat_cnt_b", bus_b.stall_count, (i > 3) ? 3 : i);
            check("sat_cnt_a", bus_a.stall_count, i);
        end
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mrst_stall_cnt", bus_b.stall_count, 0);
        check("mrst_flush_cnt", bus_b.flush_count, 0);
        check("mrst_stall_cnt_a", bus_a.stall_count, 0);
        check("mrst_sv", bus_b.stage_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end
endmodule
`default_nettype wire
